aes_result_word_streamer: RTL and testbench

- Sits directly upstream of the 32-bit HPS-readable input PIO (fpga_data). It buffers 128-bit AES result blocks from the AES core and presents them one 32-bit word at a time on word_out, which drives the PIO's in_port.
- HPS software steps through words by toggling a request bit on a control PIO. Status for HPS polling is exported on a separate 8-bit status PIO.

---
 rtl/aes_stream_pkg.sv | 27 ++
 rtl/aes_blk_fifo.sv | 65 ++++++
 rtl/aes_result_word_streamer.sv | 165 ++++++++++++++++
 tb/tb_aes_result_word_streamer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : aes_stream_pkg
//  Purpose  : Shared widths and status-bit positions for the AES result streamer.
//  Revision : 1.0 - initial release
// ============================================================================
package aes_stream_pkg;

    localparam int WORD_W        = 32;
    localparam int BLK_W         = 128;
    localparam int WORDS_PER_BLK = 4;

    localparam int ST_AVAIL    = 0;
    localparam int ST_IDX_LO   = 1;
    localparam int ST_IDX_HI   = 2;
    localparam int ST_FULL     = 3;
    localparam int ST_UNDERRUN = 4;
    localparam int ST_LVL_LO   = 5;
    localparam int ST_LVL_HI   = 7;

    // The status field is 3 bits wide; deeper levels show as 7.
    function automatic logic [2:0] lvl_disp(input int unsigned lvl);
        return (lvl > 32'd7) ? 3'd7 : lvl[2:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_blk_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : aes_blk_fifo
//  Purpose  : DEPTH x 128-bit synchronous FIFO with first-word-fall-through head.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_blk_fifo
    import aes_stream_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    push,
    input  logic [BLK_W-1:0]        push_data,
    input  logic                    pop,
    output logic [BLK_W-1:0]        head,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    logic [BLK_W-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_LVL_W-1:0] r_level;

    // Pointers are exactly log2(DEPTH) bits so they wrap without compare logic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (push && !pop) begin
                r_level <= r_level + 1'b1;
            end else if (pop && !push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    assign head  = r_mem[r_rptr];
    assign level = r_level;
    assign full  = (r_level == c_LVL_W'(DEPTH));
    assign empty = (r_level == '0);

endmodule
`default_nettype wire

// File: rtl/aes_result_word_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : aes_result_word_streamer
//  Purpose  : Buffers AES result blocks and streams them 32 bits at a time to
//             an HPS PIO; optional words_read counter via AES_STREAM_WORD_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_result_word_streamer
    import aes_stream_pkg::*;
#(
    parameter int DEPTH       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int WORD0_LSB   = 1
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              blk_valid,
    input  logic [BLK_W-1:0]  blk_data,
    output logic              blk_ready,
    input  logic              req_toggle,
    input  logic              clr_sticky,
    output logic [WORD_W-1:0] word_out,
    output logic [7:0]        status_out
`ifdef AES_STREAM_WORD_CNT_EN
    ,
    output logic [15:0]       words_read
`endif
);

    localparam int c_LVL_W = $clog2(DEPTH) + 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [1:0]             r_word_idx;
    logic                   r_underrun;
    logic                   r_blk_ready;
    logic [WORD_W-1:0]      r_word_out;
    logic [7:0]             r_status;

    logic                   w_adv;
    logic                   w_avail;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [BLK_W-1:0]       w_head;
    logic [c_LVL_W-1:0]     w_level;
    logic [c_LVL_W-1:0]     w_level_nxt;
    logic [1:0]             w_sel;
    logic [WORD_W-1:0]      w_word;
    logic [7:0]             w_status;

    generate
        if (SYNC_STAGES == 1) begin : g_sync_single
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= req_toggle;
                end
            end
        end else begin : g_sync_chain
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], req_toggle};
                end
            end
        end
    endgenerate

    assign w_adv   = r_sync[SYNC_STAGES-1] ^ r_prev;
    assign w_avail = !w_empty;
    assign w_push  = blk_valid && r_blk_ready;
    assign w_pop   = w_adv && w_avail && (r_word_idx == 2'd3);

    aes_blk_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data (blk_data),
        .pop       (w_pop),
        .head      (w_head),
        .level     (w_level),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_comb begin
        w_level_nxt = w_level;
        if (w_push && !w_pop) begin
            w_level_nxt = w_level + 1'b1;
        end else if (w_pop && !w_push) begin
            w_level_nxt = w_level - 1'b1;
        end
    end

    assign w_sel  = (WORD0_LSB != 0) ? r_word_idx : ~r_word_idx;
    assign w_word = w_head[{w_sel, 5'd0} +: WORD_W];

    always_comb begin
        w_status                        = '0;
        w_status[ST_AVAIL]              = w_avail;
        w_status[ST_IDX_HI:ST_IDX_LO]   = r_word_idx;
        w_status[ST_FULL]               = w_full;
        w_status[ST_UNDERRUN]           = r_underrun;
        w_status[ST_LVL_HI:ST_LVL_LO]   = lvl_disp(32'(w_level));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev      <= 1'b0;
            r_word_idx  <= 2'd0;
            r_underrun  <= 1'b0;
            r_blk_ready <= 1'b0;
            r_word_out  <= '0;
            r_status    <= '0;
        end else begin
            r_prev      <= r_sync[SYNC_STAGES-1];
            r_blk_ready <= (w_level_nxt != c_LVL_W'(DEPTH));
            // Index 3 wraps to 0 on the same advance that pops the head.
            if (w_adv && w_avail) begin
                r_word_idx <= r_word_idx + 2'd1;
            end
            if (w_adv && !w_avail) begin
                r_underrun <= 1'b1;
            end else if (clr_sticky) begin
                r_underrun <= 1'b0;
            end
            r_word_out  <= w_empty ? '0 : w_word;
            r_status    <= w_status;
        end
    end

    assign blk_ready  = r_blk_ready;
    assign word_out   = r_word_out;
    assign status_out = r_status;

`ifdef AES_STREAM_WORD_CNT_EN
    logic [15:0] r_cnt;
    logic [15:0] r_words_read;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt        <= '0;
            r_words_read <= '0;
        end else begin
            if (clr_sticky) begin
                r_cnt <= (w_adv && w_avail) ? 16'd1 : 16'd0;
            end else if (w_adv && w_avail) begin
                r_cnt <= r_cnt + 16'd1;
            end
            r_words_read <= r_cnt;
        end
    end

    assign words_read = r_words_read;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_result_word_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_result_word_streamer
//  Purpose  : Randomised self-checking bench with a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_result_word_streamer;

    localparam int DEPTH       = 2;
    localparam int SYNC_STAGES = 2;
    localparam int WORD0_LSB   = 1;

    logic         clk        = 1'b0;
    logic         reset_n    = 1'b0;
    logic         blk_valid  = 1'b0;
    logic [127:0] blk_data   = '0;
    logic         req_toggle = 1'b0;
    logic         clr_sticky = 1'b0;
    logic         blk_ready;
    logic [31:0]  word_out;
    logic [7:0]   status_out;
`ifdef AES_STREAM_WORD_CNT_EN
    logic [15:0]  words_read;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    aes_result_word_streamer #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES),
        .WORD0_LSB   (WORD0_LSB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .blk_valid  (blk_valid),
        .blk_data   (blk_data),
        .blk_ready  (blk_ready),
        .req_toggle (req_toggle),
        .clr_sticky (clr_sticky),
        .word_out   (word_out),
        .status_out (status_out)
`ifdef AES_STREAM_WORD_CNT_EN
        ,
        .words_read (words_read)
`endif
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [127:0] mq[$];
    int           m_idx       = 0;
    bit           m_under     = 1'b0;
    bit           m_ready     = 1'b0;
    int           m_cnt       = 0;
    int           m_adv_total = 0;
    bit           hist [0:3]  = '{default: 1'b0};
    logic [31:0]  e_word      = '0;
    logic [7:0]   e_stat      = '0;
    logic [15:0]  e_words     = '0;

    function automatic logic [31:0] word_of(input logic [127:0] b, input int i);
        int k;
        k = (WORD0_LSB != 0) ? i : 3 - i;
        return b[32*k +: 32];
    endfunction

    bit m_adv;
    bit m_acc;
    bit m_push;
    int m_lvl;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_idx       = 0;
            m_under     = 1'b0;
            m_ready     = 1'b0;
            m_cnt       = 0;
            m_adv_total = 0;
            for (int i = 0; i < 4; i++) hist[i] = 1'b0;
            e_word  = '0;
            e_stat  = '0;
            e_words = '0;
        end else begin
            m_adv  = hist[SYNC_STAGES-1] ^ hist[SYNC_STAGES];
            m_push = blk_valid && m_ready;
            m_lvl  = mq.size();
            e_word  = (m_lvl == 0) ? 32'd0 : word_of(mq[0], m_idx);
            e_stat  = {3'((m_lvl > 7) ? 7 : m_lvl), m_under, (m_lvl == DEPTH),
                       2'(m_idx), (m_lvl != 0)};
            e_words = 16'(m_cnt);
            m_acc = m_adv && (m_lvl != 0);
            if (m_adv && m_lvl == 0) m_under = 1'b1;
            else if (clr_sticky)     m_under = 1'b0;
            if (m_acc) begin
                m_adv_total++;
                if (m_idx < 3) m_idx++;
                else begin
                    void'(mq.pop_front());
                    m_idx = 0;
                end
            end
            if (m_push) mq.push_back(blk_data);
            if (clr_sticky) m_cnt = m_acc ? 1 : 0;
            else if (m_acc) m_cnt = (m_cnt + 1) % 65536;
            m_ready = (mq.size() != DEPTH);
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = req_toggle;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("word_out", 128'(word_out), 128'(e_word));
            chk("status_out", 128'(status_out), 128'(e_stat));
            chk("blk_ready", 128'(blk_ready), 128'(m_ready));
`ifdef AES_STREAM_WORD_CNT_EN
            chk("words_read", 128'(words_read), 128'(e_words));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic toggle_wait();
        req_toggle = ~req_toggle;
        step(SYNC_STAGES + 3);
    endtask

    logic [127:0] b1, b2, b3, ba, bb, bc;
    logic [31:0]  t1w [4];

    initial begin
        t1w[0] = 32'hCCDDEEFF;
        t1w[1] = 32'h8899AABB;
        t1w[2] = 32'h44556677;
        t1w[3] = 32'h00112233;
        chk_en = 1'b1;
        step(2);
        chk("rst_word_out", 128'(word_out), 128'd0);
        chk("rst_status", 128'(status_out), 128'd0);
        chk("rst_blk_ready", 128'(blk_ready), 128'd0);
        reset_n = 1'b1;
        step(1);
        chk("ready_after_rst", 128'(blk_ready), 128'd1);

        // single block, four words in order
        blk_data  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        blk_valid = 1'b1;
        step(1);
        blk_valid = 1'b0;
        step(2);
        chk("t1_word0", 128'(word_out), 128'(t1w[0]));
        chk("t1_status0", 128'(status_out), 128'h21);
        for (int i = 1; i < 4; i++) begin
            toggle_wait();
            chk("t1_word", 128'(word_out), 128'(t1w[i]));
        end
        toggle_wait();
        chk("t1_empty_status", 128'(status_out), 128'h00);
        chk("t1_empty_word", 128'(word_out), 128'd0);

        // fill to full, third block waits for a pop
        b1 = {$urandom, $urandom, $urandom, $urandom};
        b2 = {$urandom, $urandom, $urandom, $urandom};
        b3 = {$urandom, $urandom, $urandom, $urandom};
        blk_valid = 1'b1;
        blk_data  = b1;
        step(1);
        blk_data  = b2;
        step(1);
        blk_data  = b3;
        step(2);
        chk("t2_ready_full", 128'(blk_ready), 128'd0);
        chk("t2_status_full", 128'(status_out), 128'h49);
        chk("t2_head", 128'(word_out), 128'(b1[31:0]));
        for (int i = 0; i < 4; i++) toggle_wait();
        blk_valid = 1'b0;
        step(1);
        chk("t2_status_refill", 128'(status_out), 128'h49);
        chk("t2_head2", 128'(word_out), 128'(b2[31:0]));
        for (int i = 0; i < 8; i++) toggle_wait();
        chk("t2_drained", 128'(status_out), 128'h00);

        // underrun on empty, then clear
        toggle_wait();
        chk("t3_underrun", 128'(status_out), 128'h10);
        chk("t3_word", 128'(word_out), 128'd0);
        clr_sticky = 1'b1;
        step(1);
        clr_sticky = 1'b0;
        step(2);
        chk("t3_cleared", 128'(status_out), 128'h00);

        // push coinciding with the popping advance at level 1
        ba = {$urandom, $urandom, $urandom, $urandom};
        bb = {$urandom, $urandom, $urandom, $urandom};
        blk_data  = ba;
        blk_valid = 1'b1;
        step(1);
        blk_valid = 1'b0;
        step(2);
        for (int i = 0; i < 3; i++) toggle_wait();
        req_toggle = ~req_toggle;
        step(SYNC_STAGES);
        blk_data  = bb;
        blk_valid = 1'b1;
        step(1);
        blk_valid = 1'b0;
        step(3);
        chk("t4_status", 128'(status_out), 128'h21);
        chk("t4_word", 128'(word_out), 128'(bb[31:0]));
        for (int i = 0; i < 4; i++) toggle_wait();

        // asynchronous reset in the middle of a block
        bc = {$urandom, $urandom, $urandom, $urandom};
        blk_data  = bc;
        blk_valid = 1'b1;
        step(1);
        blk_valid = 1'b0;
        step(2);
        toggle_wait();
        toggle_wait();
        chk("t5_pre_word", 128'(word_out), 128'(bc[95:64]));
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t5_async_word", 128'(word_out), 128'd0);
        chk("t5_async_status", 128'(status_out), 128'd0);
        step(2);
        reset_n = 1'b1;
        step(3);
        chk("t5_after_status", 128'(status_out), 128'd0);
        toggle_wait();
        chk("t5_data_gone", 128'(status_out), 128'h10);
        clr_sticky = 1'b1;
        step(1);
        clr_sticky = 1'b0;

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            blk_valid  = ($urandom_range(0, 2) == 0);
            blk_data   = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) req_toggle = ~req_toggle;
            clr_sticky = ($urandom_range(0, 40) == 0);
            step(1);
        end
        blk_valid  = 1'b0;
        clr_sticky = 1'b0;
        step(SYNC_STAGES + 3);

`ifdef AES_STREAM_WORD_CNT_EN
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
        blk_valid = 1'b1;
        for (int i = 0; i < 90000 && m_adv_total < 65520; i++) begin
            req_toggle = ~req_toggle;
            blk_data   = {$urandom, $urandom, $urandom, $urandom};
            step(1);
        end
        step(SYNC_STAGES + 3);
        for (int i = 0; i < 100 && m_adv_total < 65537; i++) toggle_wait();
        chk("cnt_reached", 128'(m_adv_total >= 65537), 128'd1);
        chk("cnt_wrap", 128'(words_read), 128'd1);
        req_toggle = ~req_toggle;
        step(SYNC_STAGES);
        clr_sticky = 1'b1;
        step(1);
        clr_sticky = 1'b0;
        step(3);
        chk("cnt_clr_adv", 128'(words_read), 128'd1);
        blk_valid = 1'b0;
`endif

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
